gemm_input_skewer: RTL and testbench

- Parametrised N x N successor of the 2x2 GEMM input manager.
- Accepts one A column and one B row per beat through a valid/ready handshake.
- Skews lane i by i+1 register stages so operands arrive diagonally at the systolic MAC array.
- Tracks tile boundaries: drains the skew pipeline after the last beat, reports completion and beat count.

---
 rtl/gemm_input_skewer.sv | 181 ++++++++++++++++++
 tb/tb_gemm_input_skewer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_input_skewer.sv
// rtl/gemm_input_skewer.sv - N x N diagonal operand skewer feeding a systolic GEMM MAC array
module gemm_input_skewer #(
  parameter int OP_WIDTH  = 8,
  parameter int N         = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*OP_WIDTH-1:0]   new_a_column,
  input  logic [N*OP_WIDTH-1:0]   new_b_row,
  output logic [N*OP_WIDTH-1:0]   mac_a_rows,
  output logic [N-1:0]            mac_a_rows_ena,
  output logic [N*OP_WIDTH-1:0]   mac_b_columns,
  output logic [N-1:0]            mac_b_columns_ena,
  output logic                    busy,
  output logic                    tile_done,
  output logic [CNT_WIDTH-1:0]    tile_beats
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Drain lasts N-1 cycles; the counter is loaded with N-2 and exits at zero.
  localparam int                   DRAIN_W    = (N > 2) ? $clog2(N) : 1;
  localparam int                   DRAIN_INIT = (N > 1) ? (N - 2) : 0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  state_t               r_state;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_pending_beats;
  logic [CNT_WIDTH-1:0] r_tile_beats;
  logic                 r_tile_done;

  logic                 w_accept;
  logic                 w_last_accept;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_done_next;
  logic [CNT_WIDTH-1:0] w_done_beats;

  // Flush outranks a concurrent offer, so a beat in a flush cycle is dropped.
  assign in_ready      = (r_state != S_DRAIN);
  assign busy          = (r_state != S_IDLE);
  assign w_accept      = in_valid && in_ready && !flush;
  assign w_last_accept = w_accept && in_last;
  assign w_cnt_inc     = (r_beat_cnt == CNT_MAX) ? r_beat_cnt : (r_beat_cnt + 1'b1);
  assign tile_done     = r_tile_done;
  assign tile_beats    = r_tile_beats;

  // Tile state machine and saturating per-tile beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_drain_cnt     <= '0;
      r_beat_cnt      <= '0;
      r_pending_beats <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_accept) begin
            if (in_last) begin
              r_beat_cnt      <= '0;
              r_pending_beats <= w_cnt_inc;
              if (N == 1) begin
                r_state <= S_IDLE;
              end else begin
                r_state     <= S_DRAIN;
                r_drain_cnt <= DRAIN_W'(DRAIN_INIT);
              end
            end else begin
              r_beat_cnt <= w_cnt_inc;
              r_state    <= S_STREAM;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The last-beat marker travels alongside the deepest lane so completion lines up with it.
  generate
    if (N == 1) begin : g_done_direct
      assign w_done_next  = w_last_accept;
      assign w_done_beats = w_cnt_inc;
    end else begin : g_done_pipe
      logic [N-2:0] r_last_pipe;

      // Shift the last-beat marker; flush discards any tile still in flight.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_last_pipe <= '0;
        end else if (flush) begin
          r_last_pipe <= '0;
        end else begin
          r_last_pipe[0] <= w_last_accept;
          for (int j = 1; j <= N - 2; j++) begin
            r_last_pipe[j] <= r_last_pipe[j-1];
          end
        end
      end

      assign w_done_next  = r_last_pipe[N-2];
      assign w_done_beats = r_pending_beats;
    end
  endgenerate

  // Completion pulse and beat-count report; a flush suppresses the pulse but keeps the last report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tile_done  <= 1'b0;
      r_tile_beats <= '0;
    end else if (flush) begin
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= w_done_next;
      if (w_done_next) begin
        r_tile_beats <= w_done_beats;
      end
    end
  end

  // Lane i is an (i+1)-deep shift register; A and B share one valid chain since they move together.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [OP_WIDTH-1:0] r_a   [0:gi];
      logic [OP_WIDTH-1:0] r_b   [0:gi];
      logic [gi:0]         r_ena;

      // Shift every cycle; idle cycles inject zero-data, zero-valid bubbles.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int j = 0; j <= gi; j++) begin
            r_a[j] <= '0;
            r_b[j] <= '0;
          end
          r_ena <= '0;
        end else if (flush) begin
          for (int j = 0; j <= gi; j++) begin
            r_a[j] <= '0;
            r_b[j] <= '0;
          end
          r_ena <= '0;
        end else begin
          r_a[0]   <= w_accept ? new_a_column[gi*OP_WIDTH +: OP_WIDTH] : '0;
          r_b[0]   <= w_accept ? new_b_row[gi*OP_WIDTH +: OP_WIDTH]    : '0;
          r_ena[0] <= w_accept;
          for (int j = 1; j <= gi; j++) begin
            r_a[j]   <= r_a[j-1];
            r_b[j]   <= r_b[j-1];
            r_ena[j] <= r_ena[j-1];
          end
        end
      end

      assign mac_a_rows[gi*OP_WIDTH +: OP_WIDTH]    = r_a[gi];
      assign mac_b_columns[gi*OP_WIDTH +: OP_WIDTH] = r_b[gi];
      assign mac_a_rows_ena[gi]                     = r_ena[gi];
      assign mac_b_columns_ena[gi]                  = r_ena[gi];
    end
  endgenerate

endmodule

// File: tb/tb_gemm_input_skewer.sv
// tb/tb_gemm_input_skewer.sv - scoreboard bench for gemm_input_skewer (N=4 main, N=1/CNT_WIDTH=2 corner)
module tb_gemm_input_skewer;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NW = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [NW-1:0] new_a_column;
  logic [NW-1:0] new_b_row;
  logic [NW-1:0] mac_a_rows;
  logic [N-1:0]  mac_a_rows_ena;
  logic [NW-1:0] mac_b_columns;
  logic [N-1:0]  mac_b_columns_ena;
  logic          busy;
  logic          tile_done;
  logic [15:0]   tile_beats;

  logic          s_flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [W-1:0]  s_a = '0;
  logic [W-1:0]  s_b = '0;
  logic [W-1:0]  s_a_out;
  logic [0:0]    s_a_ena;
  logic [W-1:0]  s_b_out;
  logic [0:0]    s_b_ena;
  logic          s_busy;
  logic          s_done;
  logic [1:0]    s_beats;

  gemm_input_skewer #(.OP_WIDTH(W), .N(N), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .new_a_column(new_a_column), .new_b_row(new_b_row),
    .mac_a_rows(mac_a_rows), .mac_a_rows_ena(mac_a_rows_ena),
    .mac_b_columns(mac_b_columns), .mac_b_columns_ena(mac_b_columns_ena),
    .busy(busy), .tile_done(tile_done), .tile_beats(tile_beats)
  );

  gemm_input_skewer #(.OP_WIDTH(W), .N(1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .flush(s_flush), .in_valid(s_valid), .in_ready(s_ready),
    .in_last(s_last), .new_a_column(s_a), .new_b_row(s_b),
    .mac_a_rows(s_a_out), .mac_a_rows_ena(s_a_ena),
    .mac_b_columns(s_b_out), .mac_b_columns_ena(s_b_ena),
    .busy(s_busy), .tile_done(s_done), .tile_beats(s_beats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ena;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic          done;
    logic [15:0]   beats;
  } item_t;

  item_t       hist[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          drain;
  bit          stream;
  bit          g_acc;
  logic [15:0] cnt;
  logic [15:0] exp_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < N; k++) hist.push_back('0);
    drain     = 0;
    stream    = 0;
    cnt       = '0;
    exp_beats = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, mac_a_rows, '0);
    chk({tag, "_b"}, mac_b_columns, '0);
    chk({tag, "_aena"}, {28'd0, mac_a_rows_ena}, '0);
    chk({tag, "_bena"}, {28'd0, mac_b_columns_ena}, '0);
    chk({tag, "_done"}, {31'd0, tile_done}, '0);
    chk({tag, "_beats"}, {16'd0, tile_beats}, '0);
    chk({tag, "_busy"}, {31'd0, busy}, '0);
  endtask

  // One clock: drive, push the expected lane contents, clock, pop and compare.
  task automatic drive(input bit v, input bit l, input logic [NW-1:0] a, input logic [NW-1:0] b, input bit f);
    item_t       it;
    item_t       e;
    bit          exp_ready;
    logic [15:0] sat;
    in_valid     = v;
    in_last      = l;
    new_a_column = a;
    new_b_row    = b;
    flush        = f;
    exp_ready    = (drain == 0);
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    g_acc = v && exp_ready && !f;
    it    = '0;
    sat   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    if (g_acc) begin
      it.ena = 1'b1;
      it.a   = a;
      it.b   = b;
      if (l) begin
        it.done  = 1'b1;
        it.beats = sat;
      end
    end
    if (f) begin
      foreach (hist[k]) hist[k] = '0;
    end
    hist.push_back(it);
    @(posedge clk);
    #1;
    if (f) begin
      drain  = 0;
      stream = 0;
      cnt    = '0;
    end else if (g_acc && l) begin
      drain  = N - 1;
      stream = 0;
      cnt    = '0;
    end else begin
      if (drain > 0) drain--;
      if (g_acc) begin
        stream = 1;
        cnt    = sat;
      end
    end
    for (int i = 0; i < N; i++) begin
      e = hist[hist.size() - 1 - i];
      chk($sformatf("lane%0d_a", i), {24'd0, mac_a_rows[i*W +: W]}, {24'd0, e.a[i*W +: W]});
      chk($sformatf("lane%0d_b", i), {24'd0, mac_b_columns[i*W +: W]}, {24'd0, e.b[i*W +: W]});
      chk($sformatf("lane%0d_aena", i), {31'd0, mac_a_rows_ena[i]}, {31'd0, e.ena});
      chk($sformatf("lane%0d_bena", i), {31'd0, mac_b_columns_ena[i]}, {31'd0, e.ena});
    end
    e = hist[hist.size() - N];
    if (e.done) exp_beats = e.beats;
    chk("tile_done", {31'd0, tile_done}, {31'd0, e.done});
    chk("tile_beats", {16'd0, tile_beats}, {16'd0, exp_beats});
    chk("busy", {31'd0, busy}, {31'd0, (drain > 0) || stream});
    void'(hist.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0);
  endtask

  initial begin
    int got;
    reset        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    new_a_column = '0;
    new_b_row    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    reset = 1'b1;

    // single-beat tile: diagonal arrival, tile_beats=1, ready low for N-1 cycles
    drive(1, 1, 32'h04030201, 32'h40302010, 0);
    idle(5);
    chk("single_beats", {16'd0, tile_beats}, 32'd1);

    // 5-beat tile with one gap; stray in_last without in_valid is ignored
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 0);
    drive(0, 1, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 1, $urandom, $urandom, 0);
    idle(5);
    chk("gap_beats", {16'd0, tile_beats}, 32'd5);

    // two back-to-back 3-beat tiles with in_valid held high
    got = 0;
    for (int k = 0; k < 40 && got < 6; k++) begin
      drive(1, (got % 3) == 2, $urandom, $urandom, 0);
      if (g_acc) got++;
    end
    chk("b2b_accepted", got, 32'd6);
    idle(5);
    chk("b2b_beats", {16'd0, tile_beats}, 32'd3);

    // flush two beats into a tile; the offered beat in the flush cycle is dropped
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 1);
    idle(5);
    chk("flush_beats_kept", {16'd0, tile_beats}, 32'd3);

    // asynchronous reset mid-stream
    drive(1, 0, $urandom, $urandom, 0);
    drive(1, 0, $urandom, $urandom, 0);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    // N=1, CNT_WIDTH=2: never drains, done follows the last edge, count saturates at 3
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_last  = (k == 4);
      s_a     = W'(k + 1);
      s_b     = W'(8'h10 + k);
      #1;
      chk("n1_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("n1_a", {24'd0, s_a_out}, k + 1);
      chk("n1_b", {24'd0, s_b_out}, 32'h10 + k);
      chk("n1_ena", {31'd0, s_a_ena}, 32'd1);
      chk("n1_done", {31'd0, s_done}, {31'd0, k == 4});
    end
    chk("n1_beats_sat", {30'd0, s_beats}, 32'd3);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("n1_done_clear", {31'd0, s_done}, 32'd0);
    chk("n1_ena_clear", {31'd0, s_a_ena}, 32'd0);
    chk("n1_ready_after", {31'd0, s_ready}, 32'd1);
    chk("n1_beats_hold", {30'd0, s_beats}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
